breakout_game_ctrl: RTL and testbench

Top-level game sequencer for the Breakout datapath. It generates the ball step strobe that clocks the ball/brick-collision block, issues that block's reset at game start and on every serve, and tracks lives, score and bricks remaining from the ball block's erase events. It also raises the speed level as bricks fall and decides lost-life, game-over and win.

---
 rtl/breakout_pkg.sv | 20 ++
 rtl/breakout_game_ctrl_step_timer.sv | 35 +++
 rtl/breakout_game_ctrl.sv | 110 +++++++++++
 tb/tb_breakout_game_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// breakout_pkg: shared state codes, playfield constants and step divider helper
package breakout_pkg;
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      LOST  = 3'd3,
      OVER  = 3'd4,
      WIN   = 3'd5
   } state_t;
   localparam int BRICKS = 25;
   localparam int HITS = 3;
   localparam int SCREEN_H = 480;
   localparam int BALL_SIZE = 7;
   localparam int LOST_Y_DEF = SCREEN_H - BALL_SIZE + 1;
   function automatic logic [19:0] step_div(input int unsigned div, input int unsigned dec,
                                            input logic [2:0] lvl);
      return 20'(div) - 20'(lvl) * 20'(dec);
   endfunction
endpackage

// File: rtl/breakout_game_ctrl_step_timer.sv
// step_timer: programmable ball step divider with a settled-sample strobe two cycles later
module step_timer (
   input  logic        clk_50mh,
   input  logic        reset,
   input  logic        run,
   input  logic        mute,
   input  logic [19:0] divider,
   output logic        tick,
   output logic        ball_step,
   output logic        sample
);
   logic [19:0] cnt;
   logic [19:0] div_cur;
   logic        s1;
   logic        wrap;
   assign wrap = cnt == div_cur - 20'd1;
   // divider is only picked up at a wrap so a level change never shortens a period
   always_ff @(posedge clk_50mh) begin
      if (reset || !run) begin
         cnt       <= '0;
         div_cur   <= divider;
         tick      <= 1'b0;
         ball_step <= 1'b0;
         s1        <= 1'b0;
         sample    <= 1'b0;
      end else begin
         cnt       <= wrap ? '0 : cnt + 20'd1;
         div_cur   <= wrap ? divider : div_cur;
         tick      <= wrap;
         ball_step <= wrap && !mute;
         s1        <= ball_step;
         sample    <= s1;
      end
   end
endmodule

// File: rtl/breakout_game_ctrl.sv
// breakout_game_ctrl: game sequencer driving the ball block step/reset and tracking lives, score and bricks
module breakout_game_ctrl
   import breakout_pkg::*;
#(
   parameter int TICK_DIV    = 416667,
   parameter int TICK_DEC    = 62500,
   parameter int MAX_LEVEL   = 4,
   parameter int LIVES       = 3,
   parameter int SERVE_TICKS = 60,
   parameter int LOST_Y      = LOST_Y_DEF
) (
   input  logic       clk_50mh,
   input  logic       reset,
   input  logic       start,
   input  logic       erase_enable,
   input  logic [1:0] active_data,
   input  logic [9:0] ball_y,
   output logic       ball_step,
   output logic       ball_reset,
   output logic [1:0] lives,
   output logic [9:0] score,
   output logic [4:0] bricks_left,
   output logic [2:0] level,
   output logic [2:0] state
);
   state_t      st, nxt;
   logic        start_q, start_edge, fresh;
   logic        tick, sample, run, mute, ball_reset_d;
   logic        hit, win_now, lost_ball;
   logic [19:0] divider;
   logic [15:0] serve_cnt;
   logic [2:0]  k5;
   logic [2:0]  add;
   logic [10:0] score_sum;

   assign start_edge = start && !start_q;
   assign fresh      = start_edge && (st == IDLE || st == OVER || st == WIN);
   assign hit        = erase_enable && active_data == 2'(HITS);
   assign win_now    = hit && bricks_left == 5'd1;
   assign lost_ball  = ball_y >= 10'(LOST_Y);
   assign add        = erase_enable ? (hit ? 3'd6 : 3'd1) : 3'd0;
   assign score_sum  = {1'b0, score} + 11'(add);
   assign divider    = step_div(TICK_DIV, TICK_DEC, level);
   assign run        = !(st == OVER || st == WIN);
   assign mute       = st == LOST;
   assign state      = st;

   step_timer u_timer (
      .clk_50mh (clk_50mh),
      .reset    (reset),
      .run      (run),
      .mute     (mute),
      .divider  (divider),
      .tick     (tick),
      .ball_step(ball_step),
      .sample   (sample)
   );

   always_ff @(posedge clk_50mh) st <= reset ? IDLE : nxt;

   always_comb begin
      nxt = st;
      case (st)
         IDLE, OVER, WIN: nxt = start_edge ? SERVE : st;
         SERVE:           nxt = (tick && serve_cnt == 16'(SERVE_TICKS - 1)) ? PLAY : SERVE;
         PLAY:            nxt = !sample ? PLAY : win_now ? WIN : lost_ball ? LOST : PLAY;
         LOST:            nxt = !tick ? LOST : (lives != 2'd0) ? SERVE : OVER;
         default:         nxt = IDLE;
      endcase
   end

   always_comb ball_reset_d = st == IDLE || st == SERVE;

   always_ff @(posedge clk_50mh) begin
      if (reset) begin
         start_q     <= 1'b0;
         ball_reset  <= 1'b1;
         lives       <= 2'(LIVES);
         score       <= '0;
         bricks_left <= 5'(BRICKS);
         level       <= '0;
         k5          <= '0;
         serve_cnt   <= '0;
      end else begin
         start_q    <= start;
         ball_reset <= ball_reset_d;
         if (fresh) begin
            lives       <= 2'(LIVES);
            score       <= '0;
            bricks_left <= 5'(BRICKS);
            level       <= '0;
            k5          <= '0;
            serve_cnt   <= '0;
         end else if (st == LOST && nxt == SERVE) begin
            bricks_left <= 5'(BRICKS);
            serve_cnt   <= '0;
         end else if (st == SERVE && tick) begin
            serve_cnt <= serve_cnt + 16'd1;
         end else if (st == PLAY && sample) begin
            score <= score_sum > 11'd1023 ? 10'd1023 : score_sum[9:0];
            if (hit) begin
               bricks_left <= bricks_left - 5'd1;
               k5          <= k5 == 3'd4 ? 3'd0 : k5 + 3'd1;
               if (k5 == 3'd4 && level != 3'(MAX_LEVEL)) level <= level + 3'd1;
            end
            if (lost_ball && !win_now) lives <= lives - 2'd1;
         end
      end
   end
endmodule

// File: tb/tb_breakout_game_ctrl.sv
// tb_breakout_game_ctrl: scenario bench with a step-synchronised scoreboard for the game sequencer
module tb_breakout_game_ctrl;
   logic       clk_50mh = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       erase_enable = 1'b0;
   logic [1:0] active_data = 2'd0;
   logic [9:0] ball_y = 10'd0;
   logic       ball_step, ball_reset;
   logic [1:0] lives;
   logic [9:0] score;
   logic [4:0] bricks_left;
   logic [2:0] level, state;
   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [2:0] st;
      logic [1:0] lives;
      logic [9:0] score;
      logic [4:0] bricks;
      logic [2:0] level;
   } snap_t;
   snap_t exp_q[$];
   snap_t m;
   int    k5 = 0;

   breakout_game_ctrl #(.TICK_DIV(16), .TICK_DEC(2), .SERVE_TICKS(2)) dut (
      .clk_50mh    (clk_50mh),
      .reset       (reset),
      .start       (start),
      .erase_enable(erase_enable),
      .active_data (active_data),
      .ball_y      (ball_y),
      .ball_step   (ball_step),
      .ball_reset  (ball_reset),
      .lives       (lives),
      .score       (score),
      .bricks_left (bricks_left),
      .level       (level),
      .state       (state)
   );

   always #10 clk_50mh = ~clk_50mh;

   // reference model of one PLAY sample
   task automatic model_sample(input logic e, input logic [1:0] ad, input logic [9:0] y);
      int   s;
      logic h;
      h = e && ad == 2'd3;
      s = int'(m.score) + (e ? (h ? 6 : 1) : 0);
      m.score = s > 1023 ? 10'd1023 : 10'(s);
      if (h) begin
         m.bricks = m.bricks - 5'd1;
         k5++;
         if (k5 == 5) begin
            k5 = 0;
            if (m.level < 3'd4) m.level = m.level + 3'd1;
         end
      end
      if (h && m.bricks == 5'd0) m.st = 3'd5;
      else if (y >= 10'd474) begin
         m.lives = m.lives - 2'd1;
         m.st = 3'd3;
      end
   endtask

   task automatic fresh_model();
      m = '{st: 3'd2, lives: 2'd3, score: 10'd0, bricks: 5'd25, level: 3'd0};
      k5 = 0;
   endtask

   task automatic wait_step(output int n, input string tag);
      n = 0;
      do begin
         @(negedge clk_50mh);
         n++;
      end while (!ball_step && n < 100);
      if (!ball_step) begin
         checks++;
         failures++;
         $display("FAIL %s: no ball_step within %0d cycles", tag, n);
      end
   endtask

   task automatic wait_state(input logic [2:0] s, input string tag);
      int n = 0;
      while (state !== s && n < 400) begin
         @(negedge clk_50mh);
         n++;
      end
      if (state !== s) begin
         checks++;
         failures++;
         $display("FAIL %s: state=%0d required %0d after %0d cycles", tag, state, s, n);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk_50mh);
      start = 1'b0;
   endtask

   task automatic count_steps(input int cyc, output int n);
      n = 0;
      repeat (cyc) begin
         @(negedge clk_50mh);
         if (ball_step) n++;
      end
   endtask

   // drive one ball event into the sample that follows the next step and queue its expected outcome
   task automatic play_step(input logic e, input logic [1:0] ad, input logic [9:0] y);
      int n;
      wait_step(n, "play step");
      erase_enable = e;
      active_data  = ad;
      ball_y       = y;
      model_sample(e, ad, y);
      exp_q.push_back(m);
      repeat (3) @(negedge clk_50mh);
      erase_enable = 1'b0;
      active_data  = 2'd0;
      ball_y       = 10'd0;
   endtask

   // outputs settle on the third negedge after each ball_step pulse
   task automatic sb_monitor();
      logic [2:0] bs_d;
      snap_t e, g;
      bs_d = 3'd0;
      forever begin
         @(negedge clk_50mh);
         if (bs_d[2] && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {state, lives, score, bricks_left, level};
            checks++;
            if (g !== e) begin
               failures++;
               $display("FAIL scoreboard: got st=%0d lives=%0d score=%0d bricks=%0d level=%0d, required st=%0d lives=%0d score=%0d bricks=%0d level=%0d",
                        g.st, g.lives, g.score, g.bricks, g.level, e.st, e.lives, e.score, e.bricks, e.level);
            end
         end
         bs_d = {bs_d[1:0], ball_step};
      end
   endtask

   task automatic test_reset();
      int n;
      reset = 1'b1;
      repeat (3) @(negedge clk_50mh);
      checks++;
      if ({state, ball_reset, ball_step, lives, score, bricks_left, level} !==
          {3'd0, 1'b1, 1'b0, 2'd3, 10'd0, 5'd25, 3'd0}) begin
         failures++;
         $display("FAIL reset: st=%0d rst=%b step=%b lives=%0d score=%0d bricks=%0d level=%0d, required 0 1 0 3 0 25 0",
                  state, ball_reset, ball_step, lives, score, bricks_left, level);
      end
      reset = 1'b0;
      wait_step(n, "idle first step");
      checks++;
      if (n != 16) begin
         failures++;
         $display("FAIL idle first step: %0d cycles after reset, required 16", n);
      end
      wait_step(n, "idle period");
      checks++;
      if (n != 16 || state !== 3'd0 || ball_reset !== 1'b1) begin
         failures++;
         $display("FAIL idle period: period=%0d st=%0d rst=%b, required 16 0 1", n, state, ball_reset);
      end
   endtask

   task automatic test_serve();
      int n = 0;
      int g = 0;
      pulse_start();
      checks++;
      if (state !== 3'd1) begin
         failures++;
         $display("FAIL serve entry: state=%0d required 1", state);
      end
      while (state === 3'd1 && g < 400) begin
         if (ball_step) n++;
         @(negedge clk_50mh);
         g++;
      end
      checks++;
      if (n != 2 || state !== 3'd2) begin
         failures++;
         $display("FAIL serve length: steps=%0d state=%0d, required 2 and 2", n, state);
      end
      @(negedge clk_50mh);
      checks++;
      if (ball_reset !== 1'b0) begin
         failures++;
         $display("FAIL play release: ball_reset=%b required 0", ball_reset);
      end
      fresh_model();
   endtask

   task automatic test_scoring();
      play_step(1'b1, 2'd1, 10'd0);
      play_step(1'b1, 2'd3, 10'd0);
      play_step(1'b0, 2'd3, 10'd0);
      play_step(1'b1, 2'd2, 10'd473);
      pulse_start();
      repeat (2) @(negedge clk_50mh);
      checks++;
      if (state !== 3'd2 || score !== 10'd8) begin
         failures++;
         $display("FAIL start in play: state=%0d score=%0d, required 2 and 8", state, score);
      end
   endtask

   task automatic test_level_win();
      int n;
      repeat (4) play_step(1'b1, 2'd3, 10'd0);
      wait_step(n, "level old period");
      checks++;
      if (n != 13 || level !== 3'd1) begin
         failures++;
         $display("FAIL level old period: rest=%0d level=%0d, required 13 and 1", n, level);
      end
      wait_step(n, "level new period");
      checks++;
      if (n != 14) begin
         failures++;
         $display("FAIL level new period: period=%0d required 14", n);
      end
      while (m.bricks > 5'd1) play_step(1'b1, 2'd3, 10'd0);
      play_step(1'b1, 2'd3, 10'd474);
      @(negedge clk_50mh);
      count_steps(40, n);
      checks++;
      if (n != 0 || state !== 3'd5 || score !== 10'd152 || level !== 3'd4) begin
         failures++;
         $display("FAIL win: steps=%0d state=%0d score=%0d level=%0d, required 0 5 152 4", n, state, score, level);
      end
   endtask

   task automatic test_lost_over();
      int n;
      pulse_start();
      checks++;
      if ({state, lives, score, bricks_left, level} !== {3'd1, 2'd3, 10'd0, 5'd25, 3'd0}) begin
         failures++;
         $display("FAIL restart from win: st=%0d lives=%0d score=%0d bricks=%0d level=%0d, required 1 3 0 25 0",
                  state, lives, score, bricks_left, level);
      end
      wait_state(3'd2, "restart to play");
      fresh_model();
      play_step(1'b1, 2'd3, 10'd0);
      for (int i = 0; i < 3; i++) begin
         play_step(1'b0, 2'd0, 10'd474);
         wait_state(i < 2 ? 3'd1 : 3'd4, "leave lost");
         if (i < 2) begin
            checks++;
            if (bricks_left !== 5'd25 || score !== 10'd6 || lives !== 2'(2 - i)) begin
               failures++;
               $display("FAIL reserve %0d: bricks=%0d score=%0d lives=%0d, required 25 6 %0d",
                        i, bricks_left, score, lives, 2 - i);
            end
            wait_state(3'd2, "reserve to play");
            m.st = 3'd2;
            m.bricks = 5'd25;
         end
      end
      count_steps(40, n);
      checks++;
      if (n != 0 || state !== 3'd4 || lives !== 2'd0) begin
         failures++;
         $display("FAIL game over: steps=%0d state=%0d lives=%0d, required 0 4 0", n, state, lives);
      end
      pulse_start();
      checks++;
      if (state !== 3'd1 || score !== 10'd0 || lives !== 2'd3) begin
         failures++;
         $display("FAIL restart from over: state=%0d score=%0d lives=%0d, required 1 0 3", state, score, lives);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      wait_state(3'd2, "b2b play");
      fresh_model();
      wait_step(n, "b2b first");
      erase_enable = 1'b1;
      active_data  = 2'd1;
      model_sample(1'b1, 2'd1, 10'd0);
      exp_q.push_back(m);
      wait_step(n, "b2b second");
      model_sample(1'b1, 2'd1, 10'd0);
      exp_q.push_back(m);
      repeat (3) @(negedge clk_50mh);
      erase_enable = 1'b0;
      active_data  = 2'd0;
      @(negedge clk_50mh);
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      @(negedge clk_50mh);
      checks++;
      if (state !== 3'd0 || ball_reset !== 1'b1 || score !== 10'd0 || lives !== 2'd3) begin
         failures++;
         $display("FAIL mid reset: state=%0d rst=%b score=%0d lives=%0d, required 0 1 0 3",
                  state, ball_reset, score, lives);
      end
      reset = 1'b0;
   endtask

   initial begin
      fork
         sb_monitor();
      join_none
      test_reset();
      test_serve();
      test_scoring();
      test_level_win();
      test_lost_over();
      test_back_to_back();
      test_reset_mid();
      repeat (4) @(negedge clk_50mh);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard drain: %0d entries left, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
